// File: rtl/pipeline_pkg.sv
// Shared pipeline types: elastic stage state encoding and the grouping of the
// per-stage performance counters.
package pipeline_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   localparam int PERF_CNT_W = 32;

   typedef struct packed {
      logic [PERF_CNT_W-1:0] stall;
      logic [PERF_CNT_W-1:0] bubble;
   } pipe_stage_perf_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones once reached, cleared only by reset.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: main + skid register with valid/ready handshake and
// synchronous flush. Define PIPE_STAGE_PERF_EN to build the stall/bubble counters.
module pipe_stage_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   import pipeline_pkg::*;

   pipe_state_t      state;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             in_xfer;
   logic             out_xfer;

   // Both handshake outputs decode the state register alone, so ready never
   // sees a combinational path from out_ready.
   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != FULL);
   assign out_data  = main_q;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // NOTE: the payload registers are reset along with the state so out_data reads
   // zero as soon as reset rises; all state updates use non-blocking assignment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  main_q <= in_data;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (in_xfer && out_xfer) begin
                  main_q <= in_data;
               end else if (in_xfer) begin
                  skid_q <= in_data;
                  state  <= FULL;
               end else if (out_xfer) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (out_ready) begin
                  main_q <= skid_q;
                  state  <= BUSY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (~out_valid),
      .count (bubble_cnt)
   );
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a two-slot queue model checked every
// cycle, plus directed vectors with literal expectations.
module tb_pipe_stage_reg;

   localparam int WIDTH   = 32;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: the stage is a FIFO of capacity two; ready means "not full".
   logic [WIDTH-1:0] mq[$];
   int               m_stall  = 0;
   int               m_bubble = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_stall  = 0;
         m_bubble = 0;
      end else begin
         bit m_in;
         bit m_out;
`ifdef PIPE_STAGE_PERF_EN
         if (mq.size() != 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
         if (mq.size() == 0 && m_bubble < CNT_MAX) m_bubble++;
`endif
         m_in  = in_valid && (mq.size() < 2);
         m_out = (mq.size() != 0) && out_ready;
         if (flush) begin
            mq.delete();
         end else begin
            if (m_out) void'(mq.pop_front());
            if (m_in) mq.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      check("out_valid", out_valid, mq.size() != 0);
      check("in_ready", in_ready, mq.size() < 2);
      if (mq.size() != 0) check("out_data", out_data, mq[0]);
      check("stall_cnt", stall_cnt, m_stall);
      check("bubble_cnt", bubble_cnt, m_bubble);
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #2 reset  = 1'b1;
      cycle();
      reset = 1'b0;

      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_data", out_data, 32'h0);
      check("rst_stall", stall_cnt, 8'd0);

      // Five idle edges after reset release.
      repeat (5) cycle();
`ifdef PIPE_STAGE_PERF_EN
      check("idle_bubble", bubble_cnt, 8'd5);
`else
      check("idle_bubble_tied", bubble_cnt, 8'd0);
`endif

      // Streaming 1..16 with no gaps, one cycle latency.
      out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1;
         in_data  = i;
         cycle();
         check("stream_valid", out_valid, 1'b1);
         check("stream_data", out_data, i);
      end
      in_valid = 1'b0;
      cycle();
      check("stream_drained", out_valid, 1'b0);

      // Backpressure: A captured, out_ready drops, B goes to skid, C held upstream.
      in_valid = 1'b1;
      in_data  = 32'hA;
      cycle();
      check("bp_a_out", out_data, 32'hA);
      out_ready = 1'b0;
      in_data   = 32'hB;
      #1 check("bp_ready_busy", in_ready, 1'b1);
      cycle();
      check("bp_full_ready", in_ready, 1'b0);
      check("bp_hold_a", out_data, 32'hA);
      in_data = 32'hC;
      cycle();
      check("bp_still_full", in_ready, 1'b0);
      check("bp_still_a", out_data, 32'hA);
      out_ready = 1'b1;
      #1 check("bp_no_comb_ready", in_ready, 1'b0);
      cycle();
      check("bp_b_out", out_data, 32'hB);
      check("bp_ready_back", in_ready, 1'b1);
      cycle();
      check("bp_c_out", out_data, 32'hC);
      in_valid = 1'b0;
      cycle();
      check("bp_drained", out_valid, 1'b0);

      // Asynchronous reset while FULL.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h77;
      cycle();
      in_data = 32'h88;
      cycle();
      in_valid = 1'b0;
      check("pre_rst_full", in_ready, 1'b0);
      reset = 1'b1;
      #1;
      check("async_rst_valid", out_valid, 1'b0);
      check("async_rst_ready", in_ready, 1'b1);
      check("async_rst_data", out_data, 32'h0);
      cycle();
      reset = 1'b0;

      // Flush while FULL with 0xDEAD presented.
      in_valid = 1'b1;
      in_data  = 32'h11;
      cycle();
      in_data = 32'h22;
      cycle();
      in_data = 32'hDEAD;
      flush   = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_full_valid", out_valid, 1'b0);
      cycle();
      check("flush_full_no_dead", out_valid, 1'b0);

      // Flush while BUSY with in_ready high and out_ready high: input dropped.
      in_valid = 1'b1;
      in_data  = 32'h33;
      cycle();
      in_data   = 32'hDEAD;
      flush     = 1'b1;
      out_ready = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_busy_valid", out_valid, 1'b0);
      in_valid = 1'b1;
      in_data  = 32'h5;
      cycle();
      in_valid = 1'b0;
      check("post_flush_valid", out_valid, 1'b1);
      check("post_flush_data", out_data, 32'h5);
      cycle();
      check("post_flush_drained", out_valid, 1'b0);

      // Stall counting: one entry held with out_ready low for 300 cycles.
      reset = 1'b1;
      cycle();
      reset     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h99;
      cycle();
      in_valid = 1'b0;
      repeat (10) cycle();
`ifdef PIPE_STAGE_PERF_EN
      check("stall_10", stall_cnt, 8'd10);
`else
      check("stall_tied", stall_cnt, 8'd0);
`endif
      repeat (290) cycle();
`ifdef PIPE_STAGE_PERF_EN
      check("stall_sat", stall_cnt, 8'd255);
`else
      check("stall_tied_long", stall_cnt, 8'd0);
`endif
      out_ready = 1'b1;
      cycle();
      check("stall_drained", out_valid, 1'b0);

      // Random valid/ready/flush traffic, checked cycle by cycle against the model.
      for (int n = 0; n < 10000; n++) begin
         if (!(in_valid && mq.size() >= 2 && !flush)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 99) == 0);
         cycle();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (3) cycle();
      check("random_drained", out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
